// File: rtl/cnn_layer_sequencer_pkg.sv
// cnn_pkg: shared state codes, timing defaults and helpers for the CNN layer sequencer.
package cnn_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONV = 3'd1,
        S_RELU = 3'd2,
        S_POOL = 3'd3,
        S_FC   = 3'd4,
        S_HOLD = 3'd5,
        S_ERR  = 3'd7
    } state_t;
    localparam int SEQ_TIMEOUT_DEFAULT = 1024;
    localparam int CNT_W = 16;
    function automatic logic is_busy(state_t s);
        return s inside {S_CONV, S_RELU, S_POOL, S_FC};
    endfunction
    function automatic logic in_range(state_t s, state_t lo);
        return s >= lo && s <= S_HOLD;
    endfunction
endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// cnn_layer_sequencer_if: control/status bundle between the sequencer and its controller.
interface cnn_layer_sequencer_if;
    import cnn_pkg::*;
    logic             start;
    logic             abort;
    logic             result_ack;
    logic             conv_done;
    logic             relu_done;
    logic             pool_done;
    logic             fc_done;
    logic             conv_enable;
    logic             relu_enable;
    logic             pool_enable;
    logic             fc_enable;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       stage;
    logic [2:0]       err_stage;
    logic [CNT_W-1:0] cycle_count;
    modport master (
        output start, abort, result_ack, conv_done, relu_done, pool_done, fc_done,
        input  conv_enable, relu_enable, pool_enable, fc_enable, busy, done, error,
               stage, err_stage, cycle_count
    );
    modport slave (
        input  start, abort, result_ack, conv_done, relu_done, pool_done, fc_done,
        output conv_enable, relu_enable, pool_enable, fc_enable, busy, done, error,
               stage, err_stage, cycle_count
    );
endinterface

// File: rtl/cnn_layer_sequencer_stage_timer.sv
// stage_timer: per-stage watchdog; expires on the last cycle a stage is allowed to run.
module stage_timer
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || i_clear) r_cnt <= '0;
        else if (i_count) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expired = i_count && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: steps CONV->RELU->POOL->FC->HOLD with per-stage watchdog and run statistics.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    cnn_layer_sequencer_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic             r_done;
    logic [2:0]       r_err_stage;
    logic [CNT_W-1:0] r_cycle_count;
    logic             w_expired;
    logic             w_stage_done;
    logic             w_start_ok;

    assign w_start_ok = bus.start && !bus.abort && (r_state == S_IDLE || r_state == S_ERR);
    assign w_stage_done = (r_state == S_CONV && bus.conv_done) || (r_state == S_RELU && bus.relu_done) ||
                          (r_state == S_POOL && bus.pool_done) || (r_state == S_FC && bus.fc_done);

    stage_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_next != r_state),
        .i_count  (is_busy(r_state)),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // Busy stage codes are consecutive, so a stage's done advances the code by one (FC+1 = HOLD).
    always_comb begin
        w_next = r_state;
        if (bus.abort) w_next = S_IDLE;
        else if (w_start_ok) w_next = S_CONV;
        else if (w_stage_done) w_next = state_t'(r_state + 3'd1);
        else if (w_expired) w_next = S_ERR;
        else if (r_state == S_HOLD && bus.result_ack) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done        <= 1'b0;
            r_err_stage   <= 3'd0;
            r_cycle_count <= '0;
        end else begin
            r_done        <= w_next == S_HOLD && r_state != S_HOLD;
            r_err_stage   <= w_next != S_ERR ? 3'd0 : r_state == S_ERR ? r_err_stage : r_state;
            r_cycle_count <= w_start_ok ? '0 :
                             (is_busy(r_state) && r_cycle_count != '1) ? r_cycle_count + 1'b1 : r_cycle_count;
        end
    end

    // Enables stay up through HOLD so downstream stages keep their results visible.
    always_comb begin
        bus.stage       = r_state;
        bus.busy        = is_busy(r_state);
        bus.error       = r_state == S_ERR;
        bus.conv_enable = in_range(r_state, S_CONV);
        bus.relu_enable = in_range(r_state, S_RELU);
        bus.pool_enable = in_range(r_state, S_POOL);
        bus.fc_enable   = in_range(r_state, S_FC);
        bus.done        = r_done;
        bus.err_stage   = r_err_stage;
        bus.cycle_count = r_cycle_count;
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: scoreboard bench; expected status snapshots are queued by stimulus, popped on each status change.
module tb_cnn_layer_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] st = '0;
    logic [1:0] ab = '0;
    logic [1:0] ak = '0;
    logic [3:0] dn [2];
    logic [28:0] qa [$];
    logic [28:0] qb [$];
    logic [28:0] pv [2];
    logic [28:0] mon_c, mon_e;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer_if a();
    cnn_layer_sequencer_if b();

    assign a.start = st[0];
    assign a.abort = ab[0];
    assign a.result_ack = ak[0];
    assign {a.fc_done, a.pool_done, a.relu_done, a.conv_done} = dn[0];
    assign b.start = st[1];
    assign b.abort = ab[1];
    assign b.result_ack = ak[1];
    assign {b.fc_done, b.pool_done, b.relu_done, b.conv_done} = dn[1];

    cnn_layer_sequencer #(.TIMEOUT_CYCLES(8)) dut_a (.clk(clk), .rst(rst), .bus(a));
    cnn_layer_sequencer #(.TIMEOUT_CYCLES(65535)) dut_b (.clk(clk), .rst(rst), .bus(b));

    wire [28:0] va = {a.stage, a.fc_enable, a.pool_enable, a.relu_enable, a.conv_enable,
                      a.busy, a.done, a.error, a.err_stage, a.cycle_count};
    wire [28:0] vb = {b.stage, b.fc_enable, b.pool_enable, b.relu_enable, b.conv_enable,
                      b.busy, b.done, b.error, b.err_stage, b.cycle_count};

    function automatic logic [28:0] mk(int s, int en, bit bz, bit d, bit e, int es, int c);
        return {3'(s), 4'(en), bz, d, e, 3'(es), 16'(c)};
    endfunction

    task automatic push(input int u, input logic [28:0] v);
        if (u == 0) qa.push_back(v);
        else qb.push_back(v);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input int u, input int i, input int dly);
        tick(dly);
        dn[u][i] = 1'b1;
        tick();
        dn[u][i] = 1'b0;
    endtask

    task automatic do_start(input int u);
        st[u] = 1'b1;
        tick();
        st[u] = 1'b0;
    endtask

    // Monitor: any change of the non-counter status fields is one observed transaction.
    initial begin
        pv[0] = '1;
        pv[1] = '1;
    end
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mon_c = u == 0 ? va : vb;
            if (mon_c[28:16] !== pv[u][28:16]) begin
                total++;
                if ((u == 0 ? qa.size() : qb.size()) == 0) begin
                    bad++;
                    $display("FAIL unexpected_change dut%0d got=%h expected none", u, mon_c);
                end else begin
                    mon_e = u == 0 ? qa.pop_front() : qb.pop_front();
                    if (mon_c !== mon_e) begin
                        bad++;
                        $display("FAIL status dut%0d got=%h expected=%h", u, mon_c, mon_e);
                    end
                end
            end
            pv[u] = mon_c;
        end
    end

    initial begin
        dn[0] = '0;
        dn[1] = '0;
        push(0, mk(0, 0, 0, 0, 0, 0, 0));
        push(1, mk(0, 0, 0, 0, 0, 0, 0));
        tick(2);
        rst = 1'b0;
        // stray result_ack in IDLE, then happy path with done 3 cycles after each enable
        ak[0] = 1'b1;
        tick();
        ak[0] = 1'b0;
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(2, 4'b0011, 1, 0, 0, 0, 4));
        push(0, mk(3, 4'b0111, 1, 0, 0, 0, 8));
        push(0, mk(4, 4'b1111, 1, 0, 0, 0, 12));
        push(0, mk(5, 4'b1111, 0, 1, 0, 0, 16));
        push(0, mk(5, 4'b1111, 0, 0, 0, 0, 16));
        push(0, mk(0, 0, 0, 0, 0, 0, 16));
        do_start(0);
        for (int i = 0; i < 4; i++) pulse_done(0, i, 3);
        tick();
        ak[0] = 1'b1;
        tick();
        ak[0] = 1'b0;
        // stray pool_done in CONV, start in POOL, then abort beats pool_done
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(2, 4'b0011, 1, 0, 0, 0, 3));
        push(0, mk(3, 4'b0111, 1, 0, 0, 0, 4));
        push(0, mk(0, 0, 0, 0, 0, 0, 6));
        do_start(0);
        pulse_done(0, 2, 1);
        pulse_done(0, 0, 0);
        pulse_done(0, 1, 0);
        do_start(0);
        ab[0] = 1'b1;
        dn[0][2] = 1'b1;
        tick();
        ab[0] = 1'b0;
        dn[0][2] = 1'b0;
        // RELU watchdog: exactly 8 cycles in RELU, then ERR with err_stage=2
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(2, 4'b0011, 1, 0, 0, 0, 3));
        push(0, mk(7, 0, 0, 0, 1, 2, 11));
        do_start(0);
        pulse_done(0, 0, 2);
        tick(12);
        // restart from ERR; relu_done on the last allowed cycle wins over timeout
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(2, 4'b0011, 1, 0, 0, 0, 1));
        push(0, mk(3, 4'b0111, 1, 0, 0, 0, 9));
        push(0, mk(0, 0, 0, 0, 0, 0, 10));
        do_start(0);
        pulse_done(0, 0, 0);
        pulse_done(0, 1, 7);
        ab[0] = 1'b1;
        dn[0][2] = 1'b1;
        tick();
        ab[0] = 1'b0;
        dn[0][2] = 1'b0;
        // CONV timeout, then abort clears error
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(7, 0, 0, 0, 1, 1, 8));
        push(0, mk(0, 0, 0, 0, 0, 0, 8));
        do_start(0);
        tick(10);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        // rst in FC overrides fc_done and start
        push(0, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(0, mk(2, 4'b0011, 1, 0, 0, 0, 1));
        push(0, mk(3, 4'b0111, 1, 0, 0, 0, 2));
        push(0, mk(4, 4'b1111, 1, 0, 0, 0, 3));
        push(0, mk(0, 0, 0, 0, 0, 0, 0));
        do_start(0);
        for (int i = 0; i < 3; i++) pulse_done(0, i, 0);
        rst = 1'b1;
        dn[0][3] = 1'b1;
        st[0] = 1'b1;
        tick();
        rst = 1'b0;
        dn[0][3] = 1'b0;
        st[0] = 1'b0;
        tick(2);
        // cycle_count saturation on the long-timeout instance
        push(1, mk(1, 4'b0001, 1, 0, 0, 0, 0));
        push(1, mk(2, 4'b0011, 1, 0, 0, 0, 40000));
        push(1, mk(3, 4'b0111, 1, 0, 0, 0, 16'hFFFF));
        push(1, mk(4, 4'b1111, 1, 0, 0, 0, 16'hFFFF));
        push(1, mk(5, 4'b1111, 0, 1, 0, 0, 16'hFFFF));
        push(1, mk(5, 4'b1111, 0, 0, 0, 0, 16'hFFFF));
        push(1, mk(0, 0, 0, 0, 0, 0, 16'hFFFF));
        do_start(1);
        pulse_done(1, 0, 39999);
        pulse_done(1, 1, 29999);
        pulse_done(1, 2, 0);
        pulse_done(1, 3, 0);
        tick();
        ab[1] = 1'b1;
        tick();
        ab[1] = 1'b0;
        tick(5);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL pending_expected got=%0d/%0d outstanding expected=0/0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, max cycles any one stage may run before done (legal range 2..65535).
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin inference; honoured only in IDLE or ERR.
REQ-006 abort  in  1  return to IDLE from any state.
REQ-007 result_ack  in  1  consumer has read results; releases HOLD.
REQ-008 conv_done, relu_done, pool_done, fc_done  in  1 each  stage completion flags.
REQ-009 conv_enable, relu_enable, pool_enable, fc_enable  out  1 each  stage enables.
REQ-010 busy  out  1  high in CONV, RELU, POOL, FC.
REQ-011 done  out  1  one-cycle pulse on entry to HOLD.
REQ-012 error  out  1  high in ERR.
REQ-013 stage  out  3  state code: IDLE=0, CONV=1, RELU=2, POOL=3, FC=4, HOLD=5, ERR=7.
REQ-014 err_stage  out  3  code of stage that timed out; valid while error=1.
REQ-015 cycle_count  out  16  cycles spent in CONV..FC for the current/last run.

Function
REQ-016 FSM states IDLE, CONV, RELU, POOL, FC, HOLD, ERR; one transition per clk edge max.
REQ-017 IDLE/ERR + start -> CONV next cycle; start elsewhere ignored.
REQ-018 CONV->RELU on conv_done, RELU->POOL on relu_done, POOL->FC on pool_done, FC->HOLD on fc_done; only the current stage's done is sampled, others ignored.
REQ-019 Enables cumulative: conv_enable high in CONV..HOLD, relu_enable in RELU..HOLD, pool_enable in POOL..HOLD, fc_enable in FC..HOLD; all low in IDLE and ERR (pool/conv outputs clear when enable drops, so results must stay enabled through HOLD).
REQ-020 Latency: start sampled at edge N -> stage=1, conv_enable=1 after edge N; done sampled at edge M -> next stage's enable high after edge M.
REQ-021 HOLD: done=1 on first HOLD cycle only; remain until result_ack, then IDLE; result_ack outside HOLD ignored.
REQ-022 Watchdog: per-stage counter cleared on stage entry, +1 per cycle; if counter == TIMEOUT_CYCLES-1 and stage done low -> ERR next edge (stage occupies exactly TIMEOUT_CYCLES cycles).
REQ-023 On ERR entry err_stage latches the timed-out stage code; error and err_stage hold until start or abort.
REQ-024 Priority same cycle: abort > done > timeout.
REQ-025 abort in any non-IDLE state -> IDLE next cycle, all enables low, error cleared, no done pulse.
REQ-026 cycle_count cleared to 0 on start acceptance, +1 each cycle in CONV..FC, saturates at 16'hFFFF, holds in HOLD/ERR/IDLE.

Reset
REQ-027 rst -> IDLE; all enables 0, busy 0, done 0, error 0, stage 0, err_stage 0, cycle_count 0; watchdog counter 0.
REQ-028 rst mid-run has priority over all inputs; following cycle is IDLE regardless of done/start.

Structure
REQ-029 Shared package cnn_pkg holds the state/stage enum and codes and SEQ_TIMEOUT_DEFAULT=1024.
REQ-030 Watchdog implemented as sub-module stage_timer (clear, count, expired at TIMEOUT_CYCLES-1).
REQ-031 All outputs registered; no combinational path from inputs to outputs.

Verification
REQ-032 Happy path: start; each done asserted 3 cycles after its enable -> stages 1,2,3,4,5, done pulse 1 cycle, cycle_count=16, enables all high in HOLD; result_ack -> stage 0, enables 0.
REQ-033 Timeout: TIMEOUT_CYCLES=8, start, conv_done after 2 cycles, relu_done never -> RELU exactly 8 cycles, then stage=7, error=1, err_stage=2, enables 0; start -> CONV, error=0.
REQ-034 Same-cycle: relu_done asserted on last allowed cycle (counter=TIMEOUT_CYCLES-1) -> POOL, no error; abort with pool_done same cycle -> IDLE.
REQ-035 Stray inputs: pool_done high during CONV, start during POOL, result_ack in IDLE -> no state change.
REQ-036 rst asserted in FC -> next cycle stage=0, all outputs at reset values; cycle_count saturation checked with TIMEOUT_CYCLES=65535 and done withheld until count reaches 16'hFFFF.
